alu_bist: RTL and testbench
===========================

ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter: SETTLE, default 1, ALU settle cycles between driving a vector and sampling alu_out (legal 1..15).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin self-test run; sampled only in IDLE.
REQ-005 abort  input  1  synchronous abort of a run in progress.
REQ-006 alu_out  input  8  result from the ALU under test.
REQ-007 alu_a  output  8  operand A driven to the ALU (registered).
REQ-008 alu_b  output  8  operand B driven to the ALU (registered).
REQ-009 alu_op  output  4  opcode to the ALU: 0 Add, 1 Sub, 2 And, 3 Or, 4 Xor, 5 Leftshift, 6 RightshiftLogic, 7 RightshiftArith, 8 Equal (registered).
REQ-010 busy  output  1  high in WAIT or CHECK.
REQ-011 done  output  1  one-cycle pulse at run completion.
REQ-012 pass  output  1  result of the last completed run: 1 when fail_count is 0.
REQ-013 fail_count  output  4  mismatches in the current or last run.
REQ-014 first_fail_idx  output  4  index of the first failing vector; 0xF if none.
REQ-015 first_fail_out  output  8  alu_out captured at the first failure; 0x00 if none.

Function
REQ-016 Internal constant vector table, index: (A, B, op, expected): 0:(10,5,Add,15) 1:(10,5,Sub,5) 2:(0x0F,0xF0,And,0x00) 3:(0x0F,0xF0,Or,0xFF) 4:(0xAA,0x55,Xor,0xFF) 5:(10,2,Leftshift,40) 6:(128,1,RightshiftLogic,64) 7:(128,1,RightshiftArith,192) 8:(50,50,Equal,1) 9:(25,30,Equal,0).
REQ-017 FSM states: IDLE, WAIT, CHECK, DONE.
REQ-018 IDLE with start=1 -> WAIT; at the same edge load vector 0 onto alu_a/alu_b/alu_op, clear fail_count to 0, set first_fail_idx to 0xF, clear first_fail_out to 0x00, and clear pass.
REQ-019 WAIT persists exactly SETTLE cycles (internal 4-bit settle counter), then -> CHECK.
REQ-020 CHECK compares alu_out against the table expected value with full 8-bit exact equality.
REQ-021 On mismatch in CHECK: fail_count increments; if this is the first mismatch of the run, capture first_fail_idx = index and first_fail_out = alu_out.
REQ-022 CHECK at index < 9: load vector index+1 onto the outputs and -> WAIT; CHECK at index 9 -> DONE.
REQ-023 Timing: vector k is driven from edge k*(SETTLE+1) after the start edge, and DONE is entered at edge 10*(SETTLE+1); with SETTLE=1, DONE is entered at edge 20.
REQ-024 DONE lasts one cycle: done=1, pass=(fail_count==0), then -> IDLE.
REQ-025 pass, fail_count, first_fail_idx, first_fail_out and the last driven vector hold in IDLE until the next start.
REQ-026 start=1 outside IDLE is ignored; start held high across DONE begins a new run only from IDLE.
REQ-027 abort=1 in WAIT or CHECK -> IDLE at the next edge: no done pulse, pass=0, counters and captures frozen at their values before that edge (no compare recorded at that edge); abort has priority over CHECK.
REQ-028 abort in IDLE or DONE has no effect.
REQ-029 fail_count cannot exceed 10; no wrap handling is required beyond the 4-bit width.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, alu_a=0, alu_b=0, alu_op=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0xF, first_fail_out=0x00, index=0, settle counter=0.
REQ-031 Reset mid-run discards the run entirely; after release the block waits in IDLE for start.

Verification
REQ-032 Correct ALU model, SETTLE=1, start pulse -> done high exactly 20 cycles after the start edge, pass=1, fail_count=0, first_fail_idx=0xF.
REQ-033 ALU output stuck at 0x00 -> fail_count=8, pass=0, first_fail_idx=0, first_fail_out=0x00.
REQ-034 ALU with RightshiftArith implemented as logical shift -> fail_count=1, first_fail_idx=7, first_fail_out=64.
REQ-035 SETTLE=3 with a correct model -> each vector is held for 4 cycles, and done arrives 40 cycles after start with pass=1.
REQ-036 abort asserted while vector 4 is in WAIT -> IDLE next edge, done is never pulsed, pass=0; a subsequent start runs a full clean pass.
REQ-037 rst_n low during CHECK of vector 6, then released -> all outputs at their REQ-030 values, and start is pulsed again during the run with no effect.

Source files
------------

// File: rtl/alu_bist.sv
// Built-in self-test sequencer for an 8-bit ALU: drives a fixed table of
// ten vectors, waits SETTLE cycles for each one, compares the result and
// reports the mismatch count plus the first failing index and value.
module alu_bist #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] alu_out,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [3:0] first_fail_idx,
  output logic [7:0] first_fail_out
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(9);
  localparam logic [IDX_W-1:0] NO_FAIL_IDX = IDX_W'(15);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(7);
  localparam logic [OP_W-1:0] OP_EQ  = OP_W'(8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One stimulus vector as presented to the ALU
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } stim_t;

  // Stimulus half of the vector table
  function automatic stim_t stim_at(input logic [IDX_W-1:0] idx);
    stim_t s;
    s = '0;
    case (idx)
      IDX_W'(0): s = '{a: 8'd10,  b: 8'd5,   op: OP_ADD};
      IDX_W'(1): s = '{a: 8'd10,  b: 8'd5,   op: OP_SUB};
      IDX_W'(2): s = '{a: 8'h0F,  b: 8'hF0,  op: OP_AND};
      IDX_W'(3): s = '{a: 8'h0F,  b: 8'hF0,  op: OP_OR};
      IDX_W'(4): s = '{a: 8'hAA,  b: 8'h55,  op: OP_XOR};
      IDX_W'(5): s = '{a: 8'd10,  b: 8'd2,   op: OP_SHL};
      IDX_W'(6): s = '{a: 8'd128, b: 8'd1,   op: OP_SRL};
      IDX_W'(7): s = '{a: 8'd128, b: 8'd1,   op: OP_SRA};
      IDX_W'(8): s = '{a: 8'd50,  b: 8'd50,  op: OP_EQ};
      IDX_W'(9): s = '{a: 8'd25,  b: 8'd30,  op: OP_EQ};
      default:   s = '0;
    endcase
    return s;
  endfunction

  // Expected-result half of the vector table
  function automatic logic [DATA_W-1:0] exp_at(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] e;
    e = '0;
    case (idx)
      IDX_W'(0): e = 8'd15;
      IDX_W'(1): e = 8'd5;
      IDX_W'(2): e = 8'h00;
      IDX_W'(3): e = 8'hFF;
      IDX_W'(4): e = 8'hFF;
      IDX_W'(5): e = 8'd40;
      IDX_W'(6): e = 8'd64;
      IDX_W'(7): e = 8'd192;
      IDX_W'(8): e = 8'd1;
      IDX_W'(9): e = 8'd0;
      default:   e = 8'd0;
    endcase
    return e;
  endfunction

  state_t             state, state_next;
  logic [IDX_W-1:0]   index, index_next;
  logic [CNT_W-1:0]   settle_cnt, settle_cnt_next;
  logic [DATA_W-1:0]  alu_a_next, alu_b_next;
  logic [OP_W-1:0]    alu_op_next;
  logic               busy_next, done_next, pass_next;
  logic [CNT_W-1:0]   fail_count_next;
  logic [IDX_W-1:0]   first_fail_idx_next;
  logic [DATA_W-1:0]  first_fail_out_next;
  stim_t              ld;
  logic               mismatch;

  // Exact 8-bit compare of the ALU result against the current vector
  assign mismatch = (alu_out != exp_at(index));

  // Next-state and next-output logic
  always_comb begin
    state_next          = state;
    index_next          = index;
    settle_cnt_next     = settle_cnt;
    alu_a_next          = alu_a;
    alu_b_next          = alu_b;
    alu_op_next         = alu_op;
    pass_next           = pass;
    fail_count_next     = fail_count;
    first_fail_idx_next = first_fail_idx;
    first_fail_out_next = first_fail_out;
    ld                  = stim_at(IDX_W'(0));

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next          = S_WAIT;
          index_next          = IDX_W'(0);
          settle_cnt_next     = CNT_W'(0);
          alu_a_next          = ld.a;
          alu_b_next          = ld.b;
          alu_op_next         = ld.op;
          pass_next           = 1'b0;
          fail_count_next     = CNT_W'(0);
          first_fail_idx_next = NO_FAIL_IDX;
          first_fail_out_next = DATA_W'(0);
        end
      end

      S_WAIT: begin
        if (abort) begin
          state_next      = S_IDLE;
          settle_cnt_next = CNT_W'(0);
          pass_next       = 1'b0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_next      = S_CHECK;
          settle_cnt_next = CNT_W'(0);
        end else begin
          settle_cnt_next = settle_cnt + CNT_W'(1);
        end
      end

      S_CHECK: begin
        if (abort) begin
          state_next = S_IDLE;
          pass_next  = 1'b0;
        end else begin
          if (mismatch) begin
            fail_count_next = fail_count + CNT_W'(1);
            if (fail_count == CNT_W'(0)) begin
              first_fail_idx_next = index;
              first_fail_out_next = alu_out;
            end
          end
          if (index == LAST_IDX) begin
            state_next = S_DONE;
            pass_next  = !mismatch && (fail_count == CNT_W'(0));
          end else begin
            ld              = stim_at(index + IDX_W'(1));
            state_next      = S_WAIT;
            index_next      = index + IDX_W'(1);
            settle_cnt_next = CNT_W'(0);
            alu_a_next      = ld.a;
            alu_b_next      = ld.b;
            alu_op_next     = ld.op;
          end
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next == S_WAIT) || (state_next == S_CHECK);
    done_next = (state_next == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      index          <= IDX_W'(0);
      settle_cnt     <= CNT_W'(0);
      alu_a          <= DATA_W'(0);
      alu_b          <= DATA_W'(0);
      alu_op         <= OP_W'(0);
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= CNT_W'(0);
      first_fail_idx <= NO_FAIL_IDX;
      first_fail_out <= DATA_W'(0);
    end else begin
      state          <= state_next;
      index          <= index_next;
      settle_cnt     <= settle_cnt_next;
      alu_a          <= alu_a_next;
      alu_b          <= alu_b_next;
      alu_op         <= alu_op_next;
      busy           <= busy_next;
      done           <= done_next;
      pass           <= pass_next;
      fail_count     <= fail_count_next;
      first_fail_idx <= first_fail_idx_next;
      first_fail_out <= first_fail_out_next;
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: two instances (SETTLE=1 and SETTLE=3) each driving a
// behavioural ALU with selectable faults; run results are predicted from
// the vector table and the fault model.
module tb_alu_bist;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start1, abort1, busy1, done1, pass1;
  logic [7:0] alu_out1, a1, b1, ffo1;
  logic [3:0] op1, fc1, ffi1;
  logic       start3, abort3, busy3, done3, pass3;
  logic [7:0] alu_out3, a3, b3, ffo3;
  logic [3:0] op3, fc3, ffi3;

  int         mode1, mode3;
  logic [9:0] mask1, mask3;
  logic [7:0] xorv [10];

  logic [7:0] tbl_a   [10] = '{8'd10, 8'd10, 8'h0F, 8'h0F, 8'hAA, 8'd10, 8'd128, 8'd128, 8'd50, 8'd25};
  logic [7:0] tbl_b   [10] = '{8'd5, 8'd5, 8'hF0, 8'hF0, 8'h55, 8'd2, 8'd1, 8'd1, 8'd50, 8'd30};
  logic [3:0] tbl_op  [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8};
  logic [7:0] tbl_exp [10] = '{8'd15, 8'd5, 8'h00, 8'hFF, 8'hFF, 8'd40, 8'd64, 8'd192, 8'd1, 8'd0};

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] o_a, o_b, o_ffo;
  logic [3:0] o_op, o_fc, o_ffi;
  logic       o_busy, o_done, o_pass;

  localparam logic [63:0] RST_STATE = 64'({8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 8'h00});

  alu_bist #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .alu_out(alu_out1),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail_idx(ffi1), .first_fail_out(ffo1)
  );

  alu_bist #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .alu_out(alu_out3),
    .alu_a(a3), .alu_b(b3), .alu_op(op3), .busy(busy3), .done(done3), .pass(pass3),
    .fail_count(fc3), .first_fail_idx(ffi3), .first_fail_out(ffo3)
  );

  // Reference ALU behaviour
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b;
      4'd6: return a >> b;
      4'd7: return 8'($signed(a) >>> b);
      4'd8: return (a == b) ? 8'd1 : 8'd0;
      default: return 8'h00;
    endcase
  endfunction

  // ALU under test: 0 correct, 1 stuck at zero, 2 arith shift done logically, 3 random corruption
  function automatic logic [7:0] alu_dut(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                          input int mode, input logic [9:0] mask);
    logic [7:0] r;
    r = alu_ref(a, b, op);
    case (mode)
      1: r = 8'h00;
      2: if (op == 4'd7) r = a >> b;
      3: for (int i = 0; i < 10; i++)
           if (a == tbl_a[i] && b == tbl_b[i] && op == tbl_op[i] && mask[i]) r = r ^ xorv[i];
      default: ;
    endcase
    return r;
  endfunction

  assign alu_out1 = alu_dut(a1, b1, op1, mode1, mask1);
  assign alu_out3 = alu_dut(a3, b3, op3, mode3, mask3);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome after the first n vectors have been compared
  task automatic model(input int mode, input logic [9:0] mask, input int n,
                       output logic [3:0] fc, output logic [3:0] ffi, output logic [7:0] ffo);
    logic [7:0] o;
    fc = 4'd0; ffi = 4'hF; ffo = 8'h00;
    for (int i = 0; i < n; i++) begin
      o = alu_dut(tbl_a[i], tbl_b[i], tbl_op[i], mode, mask);
      if (o !== tbl_exp[i]) begin
        if (fc == 4'd0) begin ffi = 4'(i); ffo = o; end
        fc++;
      end
    end
  endtask

  task automatic snap(input int sel);
    if (sel == 1) begin
      o_a = a1; o_b = b1; o_op = op1; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_fc = fc1; o_ffi = ffi1; o_ffo = ffo1;
    end else begin
      o_a = a3; o_b = b3; o_op = op3; o_busy = busy3; o_done = done3; o_pass = pass3;
      o_fc = fc3; o_ffi = ffi3; o_ffo = ffo3;
    end
  endtask

  function automatic logic [63:0] st();
    return 64'({o_a, o_b, o_op, o_busy, o_done, o_pass, o_fc, o_ffi, o_ffo});
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v; else start3 = v;
  endtask

  task automatic set_abort(input int sel, input logic v);
    if (sel == 1) abort1 = v; else abort3 = v;
  endtask

  // One run: abort_at / reset_at are the edge (counted from the start edge) after which that event is applied
  task automatic run(input int sel, input int mode, input logic [9:0] mask, input int abort_at,
                     input int reset_at, input bit poke, input bit hold);
    int per, total, idx;
    bit stop, seen_done;
    logic [3:0] efc, effi;
    logic [7:0] effo;
    per = (sel == 1) ? 2 : 4;
    total = 10 * per;
    if (sel == 1) begin mode1 = mode; mask1 = mask; end
    else begin mode3 = mode; mask3 = mask; end
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); if (!hold) set_start(sel, 1'b0);
    stop = 1'b0;
    for (int e = 0; e < total && !stop; e++) begin
      snap(sel);
      idx = e / per;
      chk($sformatf("vec_s%0d_e%0d", sel, e), 64'({o_a, o_b, o_op, o_busy, o_done}),
          64'({tbl_a[idx], tbl_b[idx], tbl_op[idx], 1'b1, 1'b0}));
      if (e == reset_at) begin
        rst_n = 1'b0;
        #1; snap(sel); chk("reset_async", st(), RST_STATE);
        @(negedge clk); rst_n = 1'b1; set_start(sel, 1'b0);
        @(negedge clk); snap(sel); chk("reset_idle", st(), RST_STATE);
        stop = 1'b1;
      end else if (e == abort_at) begin
        set_abort(sel, 1'b1);
        @(negedge clk); set_abort(sel, 1'b0); set_start(sel, 1'b0);
        model(mode, mask, e / per, efc, effi, effo);
        snap(sel);
        chk("abort_flags", 64'({o_busy, o_done, o_pass}), 64'(3'b000));
        chk("abort_counts", 64'({o_fc, o_ffi, o_ffo}), 64'({efc, effi, effo}));
        seen_done = 1'b0;
        for (int k = 0; k < 2 * per; k++) begin
          @(negedge clk); snap(sel); seen_done = seen_done | o_done;
        end
        chk("abort_no_done", 64'(seen_done), 64'(0));
        stop = 1'b1;
      end else begin
        if (poke && !hold && e == 5) set_start(sel, 1'b1);
        if (poke && !hold && e == 6) set_start(sel, 1'b0);
        @(negedge clk);
      end
    end
    if (!stop) begin
      model(mode, mask, 10, efc, effi, effo);
      snap(sel);
      chk("done_pulse", 64'({o_busy, o_done}), 64'(2'b01));
      chk("done_result", 64'({o_pass, o_fc, o_ffi, o_ffo}), 64'({efc == 4'd0, efc, effi, effo}));
      @(negedge clk); snap(sel);
      if (hold) begin
        chk("hold_idle", 64'({o_busy, o_done}), 64'(0));
        @(negedge clk); snap(sel);
        chk("hold_restart", 64'({o_busy, o_a, o_b, o_op}), 64'({1'b1, tbl_a[0], tbl_b[0], tbl_op[0]}));
        set_start(sel, 1'b0); set_abort(sel, 1'b1);
        @(negedge clk); set_abort(sel, 1'b0); snap(sel);
        chk("hold_abort", 64'({o_busy, o_done, o_pass}), 64'(0));
      end else begin
        chk("after_done", 64'({o_busy, o_done, o_pass, o_fc, o_ffi, o_ffo, o_a, o_b, o_op}),
            64'({2'b00, efc == 4'd0, efc, effi, effo, tbl_a[9], tbl_b[9], tbl_op[9]}));
      end
    end
  endtask

  initial begin
    int sel, ab, per;
    logic [9:0] m;
    rst_n = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    mode1 = 0; mode3 = 0; mask1 = '0; mask3 = '0;
    for (int i = 0; i < 10; i++) xorv[i] = 8'h01;
    repeat (3) @(negedge clk);
    snap(1); chk("rst_s1", st(), RST_STATE);
    snap(3); chk("rst_s3", st(), RST_STATE);
    rst_n = 1'b1;
    @(negedge clk); snap(1); chk("idle_s1", st(), RST_STATE);

    run(1, 0, '0, -1, -1, 1'b1, 1'b0);
    run(1, 1, '0, -1, -1, 1'b0, 1'b0);
    run(1, 2, '0, -1, -1, 1'b0, 1'b0);
    run(3, 0, '0, -1, -1, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      sel = (r % 2 == 1) ? 3 : 1;
      per = (sel == 1) ? 2 : 4;
      for (int i = 0; i < 10; i++) xorv[i] = 8'($urandom_range(1, 255));
      m = 10'($urandom);
      if ($urandom_range(0, 2) == 0) ab = int'($urandom_range(0, 10 * per - 1));
      else ab = -1;
      run(sel, 3, m, ab, -1, 1'b0, 1'b0);
    end

    for (int i = 0; i < 10; i++) xorv[i] = 8'($urandom_range(1, 255));
    run(1, 3, 10'($urandom), 8, -1, 1'b0, 1'b0);
    run(1, 0, '0, -1, -1, 1'b0, 1'b0);
    run(3, 3, 10'($urandom), 4 * 5 + 3, -1, 1'b0, 1'b0);
    run(1, 0, '0, -1, -1, 1'b0, 1'b1);
    run(1, 0, '0, -1, 13, 1'b0, 1'b0);
    run(1, 0, '0, -1, -1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
